// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant. The grant is locked for a
// multi-beat transfer and released on the accepted last beat or on abort.
module onehot_rr_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WIDTH-1:0]                 req,
  input  logic                             rdy,
  input  logic                             lst,
  output logic [WIDTH-1:0]                 gnt,
  output logic                             gnt_vld,
  output logic [$clog2(WIDTH)-1:0]         gnt_idx
);

  localparam int WIDTH_LOG = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH_LOG-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]       gnt_q, gnt_d;
  logic [WIDTH_LOG-1:0]   gnt_idx_q, gnt_idx_d;
  logic                   gnt_vld_q, gnt_vld_d;

  logic                   release_c;
  logic [WIDTH_LOG-1:0]   next_ptr_c;
  logic [WIDTH_LOG-1:0]   arb_ptr_c;
  logic [WIDTH-1:0]       mask_c;
  logic [WIDTH-1:0]       req_masked_c;
  logic [WIDTH-1:0]       win_masked_c;
  logic [WIDTH-1:0]       win_plain_c;
  logic [WIDTH-1:0]       winner_c;

  // Thermometer mask: bits at or above the pointer are eligible in the first scan.
  function automatic logic [WIDTH-1:0] thermo_mask(input logic [WIDTH_LOG-1:0] p);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = (i >= int'(p));
    end
    return m;
  endfunction

  // Isolates the lowest set bit; result is zero or one-hot.
  function automatic logic [WIDTH-1:0] lowest_set(input logic [WIDTH-1:0] v);
    return v & (~v + {{(WIDTH-1){1'b0}}, 1'b1});
  endfunction

  function automatic logic [WIDTH_LOG-1:0] onehot_to_idx(input logic [WIDTH-1:0] v);
    logic [WIDTH_LOG-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) idx = idx | WIDTH_LOG'(i);
    end
    return idx;
  endfunction

  // Release covers both the accepted last beat and the requester dropping out.
  always_comb begin
    release_c = (state_q == BUSY) && ((rdy && lst) || !req[gnt_idx_q]);
    if (gnt_idx_q == WIDTH_LOG'(WIDTH - 1)) begin
      next_ptr_c = '0;
    end else begin
      next_ptr_c = gnt_idx_q + 1'b1;
    end
    arb_ptr_c    = release_c ? next_ptr_c : ptr_q;
    mask_c       = thermo_mask(arb_ptr_c);
    req_masked_c = req & mask_c;
    win_masked_c = lowest_set(req_masked_c);
    win_plain_c  = lowest_set(req);
    winner_c     = (|req_masked_c) ? win_masked_c : win_plain_c;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d     = winner_c;
          gnt_idx_d = onehot_to_idx(winner_c);
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (release_c) begin
          ptr_d = next_ptr_c;
          if (|req) begin
            gnt_d     = winner_c;
            gnt_idx_d = onehot_to_idx(winner_c);
          end else begin
            gnt_d     = '0;
            gnt_idx_d = '0;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        gnt_d     = '0;
        gnt_idx_d = '0;
      end
    endcase
    gnt_vld_d = |gnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = gnt_vld_q;
  assign gnt_idx = gnt_idx_q;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Directed bench for onehot_rr_arbiter (WIDTH=16) plus a randomized invariant sweep.
module tb_onehot_rr_arbiter;

  localparam int WIDTH = 16;
  localparam int WL    = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] req;
  logic             rdy;
  logic             lst;
  logic [WIDTH-1:0] gnt;
  logic             gnt_vld;
  logic [WL-1:0]    gnt_idx;

  int errors = 0;
  int checks = 0;

  onehot_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .rdy     (rdy),
    .lst     (lst),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_gnt(input string tag, input logic [WIDTH-1:0] g, input logic [WL-1:0] idx);
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_vld"}, 32'(gnt_vld), 32'(|g));
    if (|g) chk({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
  endtask

  function automatic logic [WL-1:0] enc(input logic [WIDTH-1:0] v);
    logic [WL-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) if (v[i]) r = WL'(i);
    return r;
  endfunction

  logic [WIDTH-1:0] p_gnt, p_req;
  logic             p_vld, p_rdy, p_lst;
  logic [WL-1:0]    p_idx;
  logic             hold_exp;

  initial begin
    rst = 1'b1; req = '0; rdy = 1'b0; lst = 1'b0;
    #1;
    expect_gnt("reset", '0, '0);
    chk("reset_idx", 32'(gnt_idx), 32'd0);
    step(); step();
    rst = 1'b0;

    // Idle with no requests.
    for (int i = 0; i < 5; i++) begin
      step();
      expect_gnt("idle", '0, '0);
    end

    // Single requester, back-to-back single-beat transfers without bubbles.
    req = 16'h0001; rdy = 1'b1; lst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_gnt("single", 16'h0001, 4'd0);
    end

    // Async reset mid-BUSY drops the grant before the next edge.
    rst = 1'b1;
    #1;
    expect_gnt("async_rst", '0, '0);
    #1;
    rst = 1'b0;

    // Rotation with wrap 15 -> 0.
    req = 16'h8011; rdy = 1'b1; lst = 1'b1;
    step(); expect_gnt("rr0", 16'h0001, 4'd0);
    step(); expect_gnt("rr1", 16'h0010, 4'd4);
    step(); expect_gnt("rr2", 16'h8000, 4'd15);
    step(); expect_gnt("rr3", 16'h0001, 4'd0);
    step(); expect_gnt("rr4", 16'h0010, 4'd4);
    step(); expect_gnt("rr5", 16'h8000, 4'd15);

    // Abort with nothing else pending returns to idle; pointer -> 0.
    req = '0; rdy = 1'b0; lst = 1'b0;
    step(); expect_gnt("to_idle", '0, '0);

    // Three-beat transfer with a stall on beat 2.
    req = 16'h0006;
    step(); expect_gnt("mb_a", 16'h0002, 4'd1);
    rdy = 1'b1; lst = 1'b0;
    step(); expect_gnt("mb_b", 16'h0002, 4'd1);
    rdy = 1'b0;
    step(); expect_gnt("mb_c", 16'h0002, 4'd1);
    rdy = 1'b1;
    step(); expect_gnt("mb_d", 16'h0002, 4'd1);
    lst = 1'b1;
    step(); expect_gnt("mb_e", 16'h0004, 4'd2);
    // lst without rdy must not release.
    rdy = 1'b0; lst = 1'b1;
    step(); expect_gnt("lst_no_rdy", 16'h0004, 4'd2);
    req = '0; lst = 1'b0;
    step(); expect_gnt("to_idle2", '0, '0);

    // Abort path: pointer is 3 here.
    req = 16'h0008;
    step(); expect_gnt("ab_a", 16'h0008, 4'd3);
    req = 16'h0100;
    step(); expect_gnt("ab_b", 16'h0100, 4'd8);
    // Releasing idx 8 moves pointer to 9: bit 9 beats bits 0 and 8.
    req = 16'h0301; rdy = 1'b1; lst = 1'b1;
    step(); expect_gnt("ab_c", 16'h0200, 4'd9);
    step(); expect_gnt("ab_d", 16'h0001, 4'd0);
    step(); expect_gnt("ab_e", 16'h0100, 4'd8);

    // Random sweep: structural invariants and hold behaviour each cycle.
    for (int c = 0; c < 3000; c++) begin
      p_gnt = gnt; p_vld = gnt_vld; p_idx = gnt_idx;
      req = WIDTH'($urandom) & WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) req = p_gnt | req;
      rdy = 1'($urandom_range(0, 1));
      lst = ($urandom_range(0, 2) == 0);
      p_req = req; p_rdy = rdy; p_lst = lst;
      step();
      chk("rnd_onehot", 32'((gnt & (gnt - 1'b1)) == '0), 32'd1);
      chk("rnd_vld", 32'(gnt_vld), 32'(|gnt));
      if (gnt_vld) chk("rnd_idx", 32'(gnt_idx), 32'(enc(gnt)));
      hold_exp = p_vld && p_req[p_idx] && !(p_rdy && p_lst);
      if (hold_exp) chk("rnd_hold", 32'(gnt), 32'(p_gnt));
      if (!p_vld) chk("rnd_start", 32'(gnt_vld), 32'(|p_req));
      if (gnt_vld) chk("rnd_granted_req", 32'(|(gnt & p_req)), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
